regfile_access_arbiter: RTL
===========================

# regfile_access_arbiter

Sequencer and round-robin arbiter that shares the 32x32 register file's single write port and two registered read ports among NUM_REQ requesters. It sits between client blocks (fetch/decode, writeback, debug) and `regfile`, and drives all of the register file's control inputs. It enforces the register file's access rules: reads sample only while `w_enable` is low, and read outputs are high-Z while `w_enable` is high.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request; held until accepted
- req_we  input  NUM_REQ  1 = write, 0 = read
- req_addr1  input  NUM_REQ*ADDR_W  write address (write) or read port 1 address (read)
- req_addr2  input  NUM_REQ*ADDR_W  read port 2 address (ignored for writes)
- req_wdata  input  NUM_REQ*DATA_W  write data
- req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when valid & ready at a rising edge
- rsp_valid  output  NUM_REQ  one-hot, one-cycle read response strobe
- rsp_data1, rsp_data2  output  DATA_W  read data, meaningful only while rsp_valid is nonzero
- rf_w_enable  output  1  to regfile `w_enable`
- rf_w_addr  output  ADDR_W  to regfile `w_addr`
- rf_w_data  output  DATA_W  to regfile `w_data`
- rf_r_addr1, rf_r_addr2  output  ADDR_W  to regfile read addresses
- rf_out_data1, rf_out_data2  input  DATA_W  from regfile outputs

## Operation
- FSM states:
  - IDLE: the only state that accepts requests.
  - WR
  - RD
  - RSP
- IDLE, no valid request:
  - req_ready stays 0.
  - rf_w_enable is 0.
- IDLE, one or more valid requests:
  - The arbiter picks the winner k.
  - req_ready[k]=1 combinationally in the same cycle.
  - At the edge, the request fields are latched into the rf_* registers.
  - Next state is WR if req_we[k]=1, otherwise RD.
- WR: rf_w_enable=1 for exactly one cycle; the regfile writes at the end of this cycle; next state is IDLE.
- RD: rf_w_enable=0 and rf_r_addr1/2 are stable; the regfile samples at the end of this cycle; next state is RSP.
- RSP:
  - rf_w_enable stays 0, so regfile outputs are driven, not Z.
  - rsp_valid[k]=1.
  - rsp_data1/2 = rf_out_data1/2, passed through combinationally.
  - Next state is IDLE.
- Round-robin arbitration:
  - Pointer ptr names the highest-priority index; search runs ptr, ptr+1, ... mod NUM_REQ.
  - On each accept, ptr <= k+1 mod NUM_REQ; ptr is unchanged when nothing is accepted.
- No special handling of address 0: it is an ordinary writable register.
- Write data and addresses are passed through unmodified; there are no width conversions.
- Boundary conditions:
  - A requester that drops valid before ready simply is not granted; no state is left behind.
  - Requests arriving in WR/RD/RSP wait, with req_ready=0.
  - Async reset mid-transaction aborts it: no rsp_valid, and no write is issued after reset.
  - The regfile's own reset is not driven here.
- Reset values:
  - state=IDLE, ptr=0.
  - rf_w_enable=0, rf_w_addr=0, rf_w_data=0, rf_r_addr1/2=0.
  - req_ready=0, rsp_valid=0.

## Timing
- Write: accept in cycle T; rf_w_enable high in T+1; data is readable by a read accepted at T+2 or later.
- Read: accept in T; address phase in T+1; rsp_valid in T+2; IDLE again in T+3.
- Throughput:
  - One write per 2 cycles.
  - One read per 3 cycles.
- No write is ever issued in RD or RSP, which guarantees the read turnaround.
- Read accepted right after a write (IDLE at T+2) returns the newly written value.

## Configuration
- RFARB_WRITE_PRIORITY_EN defined:
  - If any valid request has req_we=1, the winner is chosen only among writes, using the round-robin order from ptr.
  - Reads win only when no write is pending.
- Not defined: pure round-robin, with read and write treated equally.

## Structure
- Package rfarb_pkg holds:
  - the state enum (IDLE, WR, RD, RSP);
  - ADDR_W and DATA_W default constants.
- Sub-module rr_arbiter:
  - inputs: NUM_REQ request mask and ptr;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- ptr and the FSM live in the top module.

## Test plan
- Reset: assert rst=0 mid-read (in RD) → rsp_valid stays 0, all outputs return to reset values, state is IDLE after release.
- Write then read: req0 writes 1000 to r10 → rf_w_enable high for one cycle. req1 then reads r10/r2 → rsp_valid=4'b0010 two cycles after accept, with rsp_data1=1000.
- Round-robin: all four requesters read continuously → grants 0,1,2,3,0 and no requester starved. ptr wraps from 3 to 0.
- Back-to-back writes to r20=2000, r15=3000, r30=6000, then reads r15/r30 → responses 3000/6000. rf_w_enable is never high during RD/RSP.
- RFARB_WRITE_PRIORITY_EN: req0 read and req2 write valid together with ptr=0 → req2 granted first when defined, req0 first when undefined.
- Withdrawn request: req3 raises valid for one cycle while the arbiter is busy, then drops it → req3 is never granted and no write or response occurs for it.

Source files
------------

// File: rtl/rfarb_pkg.sv
// Shared types and default widths for the register-file access arbiter.
package rfarb_pkg;

  localparam int unsigned RFARB_ADDR_W = 5;
  localparam int unsigned RFARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } rfarb_state_e;

endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_pos = IDX_W'((32'(i_ptr) + off) % NUM_REQ);
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_idx          = w_pos;
        o_grant[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares the regfile write port and registered read ports among NUM_REQ clients.
// Optional RFARB_WRITE_PRIORITY_EN: pending writes win over reads.
module regfile_access_arbiter
  import rfarb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = RFARB_ADDR_W,
  parameter int unsigned DATA_W  = RFARB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr1,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr2,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data1,
  output logic [DATA_W-1:0]         rsp_data2,
  output logic                      rf_w_enable,
  output logic [ADDR_W-1:0]         rf_w_addr,
  output logic [DATA_W-1:0]         rf_w_data,
  output logic [ADDR_W-1:0]         rf_r_addr1,
  output logic [ADDR_W-1:0]         rf_r_addr2,
  input  logic [DATA_W-1:0]         rf_out_data1,
  input  logic [DATA_W-1:0]         rf_out_data2
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rfarb_state_e        r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic                r_rf_w_enable;
  logic [ADDR_W-1:0]   r_rf_w_addr;
  logic [DATA_W-1:0]   r_rf_w_data;
  logic [ADDR_W-1:0]   r_rf_r_addr1;
  logic [ADDR_W-1:0]   r_rf_r_addr2;
  logic [NUM_REQ-1:0]  r_rsp_valid;

  logic [NUM_REQ-1:0]  w_req_mask;
  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_ptr_nxt;
  logic                w_any;
  logic [ADDR_W-1:0]   w_sel_addr1;
  logic [ADDR_W-1:0]   w_sel_addr2;
  logic [DATA_W-1:0]   w_sel_wdata;

`ifdef RFARB_WRITE_PRIORITY_EN
  assign w_req_mask = (|(req_valid & req_we)) ? (req_valid & req_we) : req_valid;
`else
  assign w_req_mask = req_valid;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req   (w_req_mask),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_ptr_nxt   = (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + IDX_W'(1);
  assign w_sel_addr1 = req_addr1[32'(w_idx)*ADDR_W +: ADDR_W];
  assign w_sel_addr2 = req_addr2[32'(w_idx)*ADDR_W +: ADDR_W];
  assign w_sel_wdata = req_wdata[32'(w_idx)*DATA_W +: DATA_W];

  // Grant is only offered in IDLE and never while reset is asserted.
  assign req_ready = (r_state == IDLE && rst) ? w_grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_rf_w_enable <= 1'b0;
      r_rf_w_addr   <= '0;
      r_rf_w_data   <= '0;
      r_rf_r_addr1  <= '0;
      r_rf_r_addr2  <= '0;
      r_rsp_valid   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_idx;
            r_ptr   <= w_ptr_nxt;
            if (req_we[w_idx]) begin
              r_rf_w_enable <= 1'b1;
              r_rf_w_addr   <= w_sel_addr1;
              r_rf_w_data   <= w_sel_wdata;
              r_state       <= WR;
            end else begin
              r_rf_r_addr1 <= w_sel_addr1;
              r_rf_r_addr2 <= w_sel_addr2;
              r_state      <= RD;
            end
          end
        end
        WR: begin
          r_rf_w_enable <= 1'b0;
          r_state       <= IDLE;
        end
        RD: begin
          r_rsp_valid <= NUM_REQ'(1) << r_owner;
          r_state     <= RSP;
        end
        RSP: begin
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
        default: begin
          r_rf_w_enable <= 1'b0;
          r_rsp_valid   <= '0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_data1   = rf_out_data1;
  assign rsp_data2   = rf_out_data2;
  assign rf_w_enable = r_rf_w_enable;
  assign rf_w_addr   = r_rf_w_addr;
  assign rf_w_data   = r_rf_w_data;
  assign rf_r_addr1  = r_rf_r_addr1;
  assign rf_r_addr2  = r_rf_r_addr2;

endmodule
